ctc_word_seq: RTL and testbench
===============================

# ctc_word_seq

Parametrised word-timing and word-select sequencer for the control/timing chip, generalising the fixed 56-state system counter, instruction capture and pointer word-select into one block. It generates the serial word timing, captures the serially delivered instruction during the sync window, maintains the digit pointer, and drives `ws` for all eight arithmetic field codes. It sits between the ROM instruction stream (`is`) and the arithmetic/register chip (`ws`, `sync`).

## Interface
- `DIGITS`, 14: digits per word (2..16)
- `BPD`, 4: bits (clock cycles) per digit
- `IS_W`, 10: instruction width in bits
- `IS_START`, `DIGITS*BPD-IS_W-1`: first cycle of the sync/IS window; must satisfy `IS_START+IS_W <= DIGITS*BPD-1`

Ports:
- `cph2` in 1: system clock, all state on rising edge
- `nrst` in 1: asynchronous active-low reset
- `is` in 1: serial instruction, LSB first
- `sync` out 1: high during IS window
- `t0` out 1: high during cycle 0 of each word
- `ws` out 1: word-select for current bit
- `digit` out `$clog2(DIGITS)`: current digit index, `cnt/BPD`
- `ptr` out 4: pointer register
- `inst` out `IS_W`: instruction executing this word
- `inst_vld` out 1: one-cycle pulse in cycle 0 when `inst` updates

## Operation
- Word length N = `DIGITS*BPD`. Counter `cnt` runs 0..N-1, wraps to 0.
- `sync` = (`IS_START` <= `cnt` < `IS_START+IS_W`); on each such cycle shift `is` into the shift register MSB (LSB-first order).
- At the edge ending cycle N-1: shift register → `inst`; pointer op applied; field latched; shift register cleared.
- Arithmetic instruction: `inst[1:0]==2'b10`; field = `inst[4:2]`. Any other class: `ws`=0 for the whole word.
- Field select (d = `digit`):
  - 000 P: d==ptr
  - 001 WP: d<=ptr
  - 010 XS: d==2
  - 011 X: d<=2
  - 100 S: d==DIGITS-1
  - 101 M: 3<=d<=DIGITS-2
  - 110 W: all d
  - 111 MS: d>=3
- `ws` holds for all `BPD` cycles of every selected digit; decoded from registered `cnt`, field, `ptr` only (glitch-free).
- Pointer op: `inst[3:0]==4'b1100`; `inst[5:4]`: 00 set `ptr`=`inst[9:6]` (clamped to DIGITS-1 if larger), 01 decrement, 10 increment, 11 no-op. Inc/dec wrap modulo DIGITS (0−1→DIGITS-1, DIGITS-1+1→0).
- Pointer and arithmetic classes are exclusive; no interaction within a word.

## Timing
- Reset: `cnt`=0, `sync`=0, `t0`=1 (cycle 0), `ws`=0, `ptr`=0, `inst`=0, `inst_vld`=0, field = none (`ws`=0), shift register 0.
- Instruction latency: captured in word k, executes (ws/ptr effect) from cycle 0 of word k+1.
- `inst_vld` high exactly one cycle, cycle 0, every word after the first full word following reset.
- Reset asserted mid-word: partial instruction discarded; after release, first `inst_vld` occurs only after a complete IS window.
- `ptr` changes only at the N-1→0 boundary.

## Configuration
- `CTC_WS_EXT_FIELDS_EN`: defined → all eight fields decoded as above. Undefined → only 000–011 decoded; fields 100–111 give `ws`=0 for the word; pointer logic unchanged.

## Test plan
- Reset then 3 words idle (`is`=0): `sync` high cycles 45–54 of each 56-cycle word, `t0` at cycle 0, `ws`=0, `ptr`=0.
- Shift set-pointer with value 5 (`inst`=0b0101_00_1100): next word `ptr`=5, `inst_vld` pulse at cycle 0, `inst` matches.
- With `ptr`=5, field WP (`inst`=0b...001_10): `ws` high cycles 0–23, low 24–55; field P: high cycles 20–23 only.
- `ptr`=0 decrement → 13; `ptr`=13 increment → 0; set value 15 → 13.
- Field S/M/MS with macro: `ws` cycles 52–55 / 12–51 / 12–55; without macro: `ws`=0 all word.
- Assert `nrst` at cycle 50 mid-IS-window, release at cycle 3: no `inst_vld` until the following full window completes; outputs at reset values.

Source files
------------

// File: rtl/ctc_word_seq_if.sv
// Word-sequencer signal bundle: serial instruction in,
// timing, word-select and pointer state out.
interface ctc_word_seq_if #(
    parameter int DIGITS = 14,
    parameter int IS_W   = 10
);
    logic                      is;
    logic                      sync;
    logic                      t0;
    logic                      ws;
    logic [$clog2(DIGITS)-1:0] digit;
    logic [3:0]                ptr;
    logic [IS_W-1:0]           inst;
    logic                      inst_vld;

    modport master (
        input  is,
        output sync, t0, ws, digit, ptr, inst, inst_vld
    );

    modport slave (
        output is,
        input  sync, t0, ws, digit, ptr, inst, inst_vld
    );
endinterface

// File: rtl/ctc_word_seq.sv
// Word timing, serial instruction capture, digit pointer and ws decode.
// Macro CTC_WS_EXT_FIELDS_EN enables fields S, M, W, MS (100..111).
module ctc_word_seq #(
    parameter int DIGITS   = 14,
    parameter int BPD      = 4,
    parameter int IS_W     = 10,
    parameter int IS_START = DIGITS*BPD-IS_W-1
) (
    input  logic cph2,
    input  logic nrst,
    ctc_word_seq_if.master bus
);
    localparam int N  = DIGITS*BPD;
    localparam int CW = $clog2(N);
    localparam int DW = $clog2(DIGITS);

    localparam logic [CW-1:0] LAST   = CW'(N-1);
    localparam logic [CW-1:0] WIN_LO = CW'(IS_START);
    localparam logic [CW-1:0] WIN_HI = CW'(IS_START+IS_W-1);
    localparam logic [3:0]    PMAX   = 4'(DIGITS-1);
    localparam logic [3:0]    MMAX   = 4'(DIGITS-2);

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IS_W-1:0] sr_q, sr_d;
    logic [IS_W-1:0] inst_q, inst_d;
    logic [3:0]      ptr_q, ptr_d;
    logic            arith_q, arith_d;
    logic [2:0]      field_q, field_d;
    logic            win_q, win_d;
    logic            vld_q, vld_d;

    logic            in_win;
    logic            wrap;
    logic [15:0]     nxt;
    logic [3:0]      pset;
    logic [DW-1:0]   digit;
    logic [3:0]      dg;
    logic            sel;

    assign in_win = (cnt_q >= WIN_LO) && (cnt_q <= WIN_HI);
    assign wrap   = (cnt_q == LAST);
    assign nxt    = 16'(sr_q);
    assign pset   = (nxt[9:6] > PMAX) ? PMAX : nxt[9:6];
    assign digit  = DW'(cnt_q / CW'(BPD));
    assign dg     = 4'(digit);

    // Counter, instruction shift/capture and pointer update.
    always_comb begin
        cnt_d   = wrap ? '0 : cnt_q + 1'b1;
        sr_d    = sr_q;
        inst_d  = inst_q;
        ptr_d   = ptr_q;
        arith_d = arith_q;
        field_d = field_q;
        win_d   = win_q;
        vld_d   = 1'b0;
        if (in_win) begin
            sr_d = {bus.is, sr_q[IS_W-1:1]};
            if (cnt_q == WIN_HI) begin
                win_d = 1'b1;
            end
        end
        if (wrap) begin
            sr_d  = '0;
            win_d = 1'b0;
            vld_d = win_q;
            if (win_q) begin
                inst_d  = sr_q;
                arith_d = (nxt[1:0] == 2'b10);
                field_d = nxt[4:2];
                if (nxt[3:0] == 4'b1100) begin
                    case (nxt[5:4])
                        2'b00:   ptr_d = pset;
                        2'b01:   ptr_d = (ptr_q == 4'd0) ? PMAX : ptr_q - 4'd1;
                        2'b10:   ptr_d = (ptr_q == PMAX) ? 4'd0 : ptr_q + 4'd1;
                        default: ptr_d = ptr_q;
                    endcase
                end
            end
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge cph2 or negedge nrst) begin
        if (!nrst) begin
            cnt_q   <= '0;
            sr_q    <= '0;
            inst_q  <= '0;
            ptr_q   <= '0;
            arith_q <= 1'b0;
            field_q <= '0;
            win_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            inst_q  <= inst_d;
            ptr_q   <= ptr_d;
            arith_q <= arith_d;
            field_q <= field_d;
            win_q   <= win_d;
            vld_q   <= vld_d;
        end
    end

    // Digit selection for the latched field, from registers only.
    always_comb begin
        sel = 1'b0;
        case (field_q)
            3'd0:    sel = (dg == ptr_q);
            3'd1:    sel = (dg <= ptr_q);
            3'd2:    sel = (dg == 4'd2);
            3'd3:    sel = (dg <= 4'd2);
`ifdef CTC_WS_EXT_FIELDS_EN
            3'd4:    sel = (dg == PMAX);
            3'd5:    sel = (dg >= 4'd3) && (dg <= MMAX);
            3'd6:    sel = 1'b1;
            3'd7:    sel = (dg >= 4'd3);
`endif
            default: sel = 1'b0;
        endcase
    end

    assign bus.sync     = in_win;
    assign bus.t0       = (cnt_q == '0);
    assign bus.ws       = arith_q & sel;
    assign bus.digit    = digit;
    assign bus.ptr      = ptr_q;
    assign bus.inst     = inst_q;
    assign bus.inst_vld = vld_q;
endmodule

// File: tb/tb_ctc_word_seq.sv
// Scoreboard bench for ctc_word_seq: word-level reference model,
// directed field/pointer words, random words and a mid-word reset.
module tb_ctc_word_seq;
    localparam int DIGITS   = 14;
    localparam int BPD      = 4;
    localparam int IS_W     = 10;
    localparam int N        = DIGITS*BPD;
    localparam int IS_START = N-IS_W-1;
`ifdef CTC_WS_EXT_FIELDS_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    typedef struct packed {
        logic       sync;
        logic       t0;
        logic       ws;
        logic [3:0] digit;
        logic [3:0] ptr;
        logic [9:0] inst;
        logic       vld;
    } obs_t;

    logic cph2 = 1'b0;
    logic nrst = 1'b0;

    ctc_word_seq_if #(.DIGITS(DIGITS), .IS_W(IS_W)) bus();

    ctc_word_seq #(
        .DIGITS(DIGITS), .BPD(BPD), .IS_W(IS_W), .IS_START(IS_START)
    ) dut (
        .cph2(cph2),
        .nrst(nrst),
        .bus(bus)
    );

    always #5 cph2 = ~cph2;

    int         m_ptr;
    logic [9:0] m_inst;
    bit         m_done;

    obs_t exp_q[$];
    int   cyc_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic obs_t model_obs(int c);
        obs_t o;
        int   d;
        bit   s;
        d = c / BPD;
        s = 1'b0;
        if (m_inst[1:0] == 2'b10) begin
            case (int'(m_inst[4:2]))
                0: s = (d == m_ptr);
                1: s = (d <= m_ptr);
                2: s = (d == 2);
                3: s = (d <= 2);
                4: s = EXT && (d == DIGITS-1);
                5: s = EXT && (d >= 3) && (d <= DIGITS-2);
                6: s = EXT;
                default: s = EXT && (d >= 3);
            endcase
        end
        o.sync  = (c >= IS_START) && (c < IS_START+IS_W);
        o.t0    = (c == 0);
        o.ws    = s;
        o.digit = 4'(d);
        o.ptr   = 4'(m_ptr);
        o.inst  = m_inst;
        o.vld   = (c == 0) && m_done;
        return o;
    endfunction

    task automatic push(int c);
        exp_q.push_back(model_obs(c));
        cyc_q.push_back(c);
    endtask

    task automatic apply(logic [9:0] ins);
        int v;
        m_inst = ins;
        m_done = 1'b1;
        if (ins[3:0] == 4'b1100) begin
            case (ins[5:4])
                2'b00: begin
                    v     = int'(ins[9:6]);
                    m_ptr = (v > DIGITS-1) ? DIGITS-1 : v;
                end
                2'b01:   m_ptr = (m_ptr + DIGITS - 1) % DIGITS;
                2'b10:   m_ptr = (m_ptr + 1) % DIGITS;
                default: m_ptr = m_ptr;
            endcase
        end
    endtask

    task automatic reset_seq(int k);
        nrst   = 1'b0;
        m_ptr  = 0;
        m_inst = '0;
        m_done = 1'b0;
        repeat (k) begin
            push(0);
            @(negedge cph2);
        end
        nrst = 1'b1;
    endtask

    task automatic run_word(logic [9:0] ins, int rst_at);
        for (int c = 0; c < N; c++) begin
            if (c == rst_at) begin
                reset_seq(3);
                return;
            end
            if (c >= IS_START && c < IS_START+IS_W)
                bus.is = ins[c-IS_START];
            else
                bus.is = 1'($urandom);
            push(c);
            @(negedge cph2);
        end
        apply(ins);
    endtask

    function automatic logic [9:0] p_set(int v);
        return {4'(v), 2'b00, 4'b1100};
    endfunction

    function automatic logic [9:0] ar(int f);
        return {5'b0, 3'(f), 2'b10};
    endfunction

    function automatic logic [9:0] rnd_ins();
        logic [9:0] r;
        int k;
        r = 10'($urandom);
        k = $urandom_range(0, 2);
        if (k == 0) r[3:0] = 4'b1100;
        else if (k == 1) r[1:0] = 2'b10;
        return r;
    endfunction

    // Monitor: compare every presented cycle against the scoreboard.
    initial begin
        obs_t e;
        obs_t a;
        int   c;
        forever begin
            @(negedge cph2);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                a = '{bus.sync, bus.t0, bus.ws, 4'(bus.digit),
                      bus.ptr, bus.inst, bus.inst_vld};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL cyc%0d @%0t: got sync=%b t0=%b ws=%b d=%0d ptr=%0d inst=%h vld=%b, want sync=%b t0=%b ws=%b d=%0d ptr=%0d inst=%h vld=%b",
                        c, $time, a.sync, a.t0, a.ws, a.digit, a.ptr, a.inst,
                        a.vld, e.sync, e.t0, e.ws, e.digit, e.ptr, e.inst,
                        e.vld);
                end
            end
        end
    end

    // Stimulus: directed words, random words, mid-word reset.
    initial begin
        bus.is = 1'b0;
        nrst   = 1'b0;
        @(negedge cph2);
        reset_seq(2);
        repeat (3) run_word(10'd0, -1);
        run_word(p_set(5), -1);
        run_word(ar(1), -1);
        run_word(ar(0), -1);
        run_word(ar(2), -1);
        run_word(ar(3), -1);
        run_word(p_set(0), -1);
        run_word({4'd0, 2'b01, 4'b1100}, -1);
        run_word({4'd0, 2'b10, 4'b1100}, -1);
        run_word(p_set(15), -1);
        run_word({4'd3, 2'b11, 4'b1100}, -1);
        run_word(ar(4), -1);
        run_word(ar(5), -1);
        run_word(ar(7), -1);
        run_word(ar(6), -1);
        run_word(10'd0, -1);
        repeat (40) run_word(rnd_ins(), -1);
        run_word(p_set(9), -1);
        run_word(p_set(7), 50);
        run_word(ar(1), -1);
        run_word(ar(1), -1);
        run_word(10'd0, -1);
        repeat (30) run_word(rnd_ins(), -1);
        @(negedge cph2);
        #5;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
